// File: rtl/hazard_unit.sv
// Pipeline hazard unit: EX/ID forwarding selects, load-use/branch/mult-div stalls,
// a mult/div busy tracker and a saturating stalled-cycle counter.
module hazard_unit #(
  parameter int unsigned MD_LAT = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs_D,
  input  logic [4:0] Rt_D,
  input  logic [4:0] Rs_E,
  input  logic [4:0] Rt_E,
  input  logic [4:0] WriteReg_E,
  input  logic [4:0] WriteReg_M,
  input  logic [4:0] WriteReg_W,
  input  logic       RegWrite_E,
  input  logic       RegWrite_M,
  input  logic       RegWrite_W,
  input  logic       MemtoReg_E,
  input  logic       MemtoReg_M,
  input  logic       Branch_D,
  input  logic       MDStart_E,
  input  logic       MDUse_D,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       MDBusy,
  output logic       MDDone,
  output logic [15:0] StallCount
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [5:0] MD_LOAD = 6'(MD_LAT - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic lwstall, branchstall, mdstall, stall;

  // Register $0 is hardwired, so it never produces a match.
  function automatic logic hit(input logic en, input logic [4:0] dst, input logic [4:0] src);
    return en && (src != 5'd0) && (dst == src);
  endfunction

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (!reset) begin
      if (hit(RegWrite_M, WriteReg_M, Rs_E))      ForwardAE = 2'b10;
      else if (hit(RegWrite_W, WriteReg_W, Rs_E)) ForwardAE = 2'b01;
      if (hit(RegWrite_M, WriteReg_M, Rt_E))      ForwardBE = 2'b10;
      else if (hit(RegWrite_W, WriteReg_W, Rt_E)) ForwardBE = 2'b01;
      ForwardAD = hit(RegWrite_M, WriteReg_M, Rs_D);
      ForwardBD = hit(RegWrite_M, WriteReg_M, Rt_D);
    end
  end

  always_comb begin
    lwstall     = hit(MemtoReg_E, Rt_E, Rs_D) || hit(MemtoReg_E, Rt_E, Rt_D);
    branchstall = Branch_D &&
                  (hit(RegWrite_E, WriteReg_E, Rs_D) || hit(RegWrite_E, WriteReg_E, Rt_D) ||
                   hit(MemtoReg_M, WriteReg_M, Rs_D) || hit(MemtoReg_M, WriteReg_M, Rt_D));
    mdstall     = (state_q == BUSY) && MDUse_D;
    stall       = !reset && (lwstall || branchstall || mdstall);
  end

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

  // Counter holds the remaining busy cycles after the current one; a start
  // request seen while BUSY (including the exit cycle) is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MDStart_E) begin
          state_d = BUSY;
          cnt_d   = MD_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q != 6'd0) begin
          cnt_d = cnt_q - 6'd1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      done_q      <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MDBusy     = (state_q == BUSY);
  assign MDDone     = done_q;
  assign StallCount = stall_cnt_q;

endmodule
